oka_seq_clmul: RTL and testbench
================================

// Module: oka_seq_clmul
// PURPOSE
//  - Iterative 2-term Karatsuba carry-less (GF(2)[x]) multiplier, parametrised in WIDTH.
//  - Time-multiplexes ONE half-width multiplier over three cycles (z0, z1, z2), then recombines.
//  - Successor to the fixed 64-bit combinational Karatsuba stage; adds valid/ready handshakes and
//    optional field reduction. Sits between operand staging and the GF-arithmetic datapath.
// PARAMETERS
//  - WIDTH  64     operand width; even, >= 4; H = WIDTH/2
//  - POLY   'h1B   low terms of reduction polynomial P(x) = x^WIDTH + POLY (used only with reduction)
// PORTS
//  - clk        in   1          clock, all state on rising edge
//  - rst_n      in   1          synchronous active-low reset
//  - in_valid   in   1          operand pair offered
//  - in_ready   out  1          block can accept operands (high only in IDLE)
//  - a          in   WIDTH      operand A
//  - b          in   WIDTH      operand B
//  - out_valid  out  1          result valid, held until consumed
//  - out_ready  in   1          consumer accepts result
//  - y          out  2*WIDTH-1  full carry-less product a*b
//  - y_red      out  WIDTH      a*b mod P(x) (port present only with OKA_MOD_REDUCE_EN)
//  - busy       out  1          high in any state except IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, out_valid=0, y=0, y_red=0, internal a/b/z regs=0; in_ready=1 after.
//  - Reset mid-operation aborts: partial products discarded, next cycle IDLE, no out_valid pulse.
//  - FSM: IDLE -> S_LO -> S_MID -> S_HI -> [S_RED] -> DONE -> IDLE.
//    IDLE : in_ready=1; in_valid&in_ready registers a,b -> S_LO.
//    S_LO : z0 <= clmul(a[H-1:0], b[H-1:0]).
//    S_MID: z1 <= clmul(a_lo^a_hi, b_lo^b_hi).
//    S_HI : z2 = clmul(a_hi, b_hi); y <= z0 ^ ((z0^z1^z2) << H) ^ (z2 << 2H), truncated to 2W-1 bits.
//    S_RED: (macro only) y_red <= y mod P(x).
//    DONE : out_valid=1; y,y_red stable; out_ready -> IDLE, out_valid low next cycle.
//  - Half products are 2H-1 = WIDTH-1 bits; middle term XOR-aligned at bit H; no carries anywhere.
//  - Latency: accept edge to out_valid high = 4 cycles (5 with reduction). Throughput: one op per
//    5 cycles (6) with out_ready held high; no overlap of operations.
//  - in_valid while busy: ignored (in_ready=0), operands must be held by source per handshake.
//  - out_ready low: stays in DONE indefinitely, y constant, in_ready=0.
//  - a or b zero -> y=0 via normal path (no short-cut, latency unchanged).
// CONFIGURATION
//  - OKA_MOD_REDUCE_EN defined: S_RED state, y_red port, POLY used; reduction folds bits
//    [2W-2:W] down via POLY in one registered stage.
//  - Undefined: no S_RED, no y_red port, POLY unused; FSM goes S_HI -> DONE.
// STRUCTURE
//  - Package oka_pkg: state enum (IDLE,S_LO,S_MID,S_HI,S_RED,DONE), localparam for 3-bit state
//    width, function clmul_ref(a,b) for the bench model.
//  - Sub-module clmul_half: combinational H x H carry-less multiplier (AND/XOR array), output 2H-1;
//    single instance, inputs muxed by state.
//  - Top: FSM, operand/partial-product registers, recombination XOR, optional reduction.
// TESTING
//  - W=64: a=1, b=1 -> y=1, out_valid 4 cycles after accept, busy high cycles 1..4.
//  - W=64: a=3, b=3 -> y=5; a=b=2^63 -> y=2^126 only.
//  - W=8: a=b=8'hFF -> y=15'h5555; random 10k pairs vs clmul_ref, WIDTH in {8,16,64}.
//  - Backpressure: out_ready low 10 cycles -> y stable, in_ready=0, in_valid pulses ignored.
//  - Reset in S_MID -> next cycle IDLE, out_valid=0, y=0; following op correct.
//  - OKA_MOD_REDUCE_EN, W=8, POLY=8'h1B: a=8'h57, b=8'h83 -> y_red=8'hC1; W=64: a=2^63, b=2 -> y_red=64'h1B.

Source files
------------

// File: rtl/oka_pkg.sv
// Shared types and helpers for the iterative Karatsuba carry-less multiplier.
//   state_t   : FSM states (IDLE, S_LO, S_MID, S_HI, S_RED, DONE)
//   STATE_W   : state encoding width
//   clmul_ref : plain 64x64 carry-less product, intended for bench models
package oka_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    S_LO  = 3'd1,
    S_MID = 3'd2,
    S_HI  = 3'd3,
    S_RED = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Schoolbook GF(2)[x] product; narrower operands are zero-extended by the caller.
  function automatic logic [126:0] clmul_ref(input logic [63:0] a, input logic [63:0] b);
    logic [126:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) r ^= 127'(a) << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/clmul_half.sv
// Combinational H x H carry-less multiplier (AND/XOR array).
//   a, b : H-bit operands
//   p_c  : 2H-1 bit carry-less product
module clmul_half #(
  parameter int unsigned H = 32
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-2:0] p_c
);

  localparam int unsigned PW = 2 * H - 1;

  // Each set bit of b contributes a shifted copy of a; XOR replaces addition.
  always_comb begin
    p_c = '0;
    for (int i = 0; i < int'(H); i++) begin
      if (b[i]) p_c ^= PW'(a) << i;
    end
  end

endmodule

// File: rtl/oka_seq_clmul.sv
// Iterative 2-term Karatsuba carry-less multiplier. One half-width multiplier is
// reused over three cycles (z0, z1, z2) and the partial products are recombined.
// Optional reduction mod P(x) = x^WIDTH + POLY when OKA_MOD_REDUCE_EN is defined.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   a, b                : WIDTH-bit operands
//   out_valid/out_ready : result handshake, result held until consumed
//   y                   : full 2*WIDTH-1 bit product
//   y_red               : reduced product (OKA_MOD_REDUCE_EN only)
//   busy                : high whenever not IDLE
module oka_seq_clmul
  import oka_pkg::*;
#(
  parameter int unsigned      WIDTH = 64,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'('h1B)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] y,
`ifdef OKA_MOD_REDUCE_EN
  output logic [WIDTH-1:0]   y_red,
`endif
  output logic               busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned ZW = WIDTH - 1;
  localparam int unsigned YW = 2 * WIDTH - 1;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic [ZW-1:0]    z0_q, z1_q;
  logic [H-1:0]     m_a_c, m_b_c;
  logic [ZW-1:0]    mul_c;
  logic [ZW-1:0]    zmid_c;
  logic [YW-1:0]    y_nxt_c;

  // Shared half-width multiplier; operands selected by state.
  clmul_half #(.H(H)) u_half (
    .a   (m_a_c),
    .b   (m_b_c),
    .p_c (mul_c)
  );

  // Next state and multiplier operand selection.
  always_comb begin
    state_nxt = state;
    m_a_c     = a_q[H-1:0];
    m_b_c     = b_q[H-1:0];
    unique case (state)
      IDLE:  if (in_valid) state_nxt = S_LO;
      S_LO:  state_nxt = S_MID;
      S_MID: begin
        m_a_c     = a_q[H-1:0] ^ a_q[WIDTH-1:H];
        m_b_c     = b_q[H-1:0] ^ b_q[WIDTH-1:H];
        state_nxt = S_HI;
      end
      S_HI: begin
        m_a_c = a_q[WIDTH-1:H];
        m_b_c = b_q[WIDTH-1:H];
`ifdef OKA_MOD_REDUCE_EN
        state_nxt = S_RED;
`else
        state_nxt = DONE;
`endif
      end
      S_RED: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Karatsuba recombination; z2 comes straight from the multiplier in S_HI.
  always_comb begin
    zmid_c  = z0_q ^ z1_q ^ mul_c;
    y_nxt_c = YW'(z0_q) ^ (YW'(zmid_c) << H) ^ (YW'(mul_c) << WIDTH);
  end

  // State, operand and partial-product registers; handshake outputs follow next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      z0_q      <= '0;
      z1_q      <= '0;
      y         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      if (state == IDLE && in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == S_LO)  z0_q <= mul_c;
      if (state == S_MID) z1_q <= mul_c;
      if (state == S_HI)  y    <= y_nxt_c;
    end
  end

`ifdef OKA_MOD_REDUCE_EN
  logic [WIDTH-1:0] red_c;
  logic             carry_c;

  // Horner-style fold, MSB first: shift remainder, replace x^WIDTH overflow by POLY.
  always_comb begin
    red_c   = '0;
    carry_c = 1'b0;
    for (int i = int'(YW) - 1; i >= 0; i--) begin
      carry_c = red_c[WIDTH-1];
      red_c   = {red_c[WIDTH-2:0], y[i]};
      if (carry_c) red_c ^= POLY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_red <= '0;
    end else if (state == S_RED) begin
      y_red <= red_c;
    end
  end
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

endmodule

// File: tb/tb_oka_seq_clmul.sv
// Bench for oka_seq_clmul: three instances (WIDTH 64/16/8) driven in lockstep,
// checked against a shift-and-XOR product model and polynomial long division.
module tb_oka_seq_clmul;

`ifdef OKA_MOD_REDUCE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic [63:0] a64, b64;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic ir64, ir16, ir8, ov64, ov16, ov8, busy64, busy16, busy8;
  logic [126:0] y64;
  logic [30:0]  y16;
  logic [14:0]  y8;
`ifdef OKA_MOD_REDUCE_EN
  logic [63:0] yr64;
  logic [15:0] yr16;
  logic [7:0]  yr8;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] exp64, exp16, exp8;
  logic [63:0]  expr64, expr16, expr8;

  always #5 clk = ~clk;

  oka_seq_clmul #(.WIDTH(64), .POLY(64'h1B)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(out_ready), .y(y64),
`ifdef OKA_MOD_REDUCE_EN
    .y_red(yr64),
`endif
    .busy(busy64));

  oka_seq_clmul #(.WIDTH(16), .POLY(16'h1B)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(out_ready), .y(y16),
`ifdef OKA_MOD_REDUCE_EN
    .y_red(yr16),
`endif
    .busy(busy16));

  oka_seq_clmul #(.WIDTH(8), .POLY(8'h1B)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(out_ready), .y(y8),
`ifdef OKA_MOD_REDUCE_EN
    .y_red(yr8),
`endif
    .busy(busy8));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Product as the XOR of shifted copies of x, one per set bit of z.
  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] z, input int w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w; i++) if (z[i]) r ^= 128'(x) << i;
    return r;
  endfunction

  // Remainder by long division with P(x) = x^w + poly.
  function automatic logic [63:0] ref_mod(input logic [127:0] p, input int w, input logic [63:0] poly);
    logic [127:0] full;
    full = 128'(poly) | (128'(1) << w);
    for (int i = 2 * w - 2; i >= w; i--) if (p[i]) p ^= full << (i - w);
    return p[63:0];
  endfunction

  task automatic set_ops(input logic [63:0] x64, input logic [63:0] z64, input logic [15:0] x16,
                         input logic [15:0] z16, input logic [7:0] x8, input logic [7:0] z8);
    a64 = x64; b64 = z64; a16 = x16; b16 = z16; a8 = x8; b8 = z8;
    exp64  = ref_mul(x64, z64, 64);
    exp16  = ref_mul(64'(x16), 64'(z16), 16);
    exp8   = ref_mul(64'(x8), 64'(z8), 8);
    expr64 = ref_mod(exp64, 64, 64'h1B);
    expr16 = ref_mod(exp16, 16, 64'h1B);
    expr8  = ref_mod(exp8, 8, 64'h1B);
  endtask

  // One full transaction with out_ready held high; returns at the DONE sample point.
  task automatic do_op(input logic [63:0] x64, input logic [63:0] z64, input logic [15:0] x16,
                       input logic [15:0] z16, input logic [7:0] x8, input logic [7:0] z8,
                       input bit timing);
    int k;
    @(negedge clk);
    if (timing) begin
      chk("idle_in_ready", 128'(ir64), 128'(1));
      chk("idle_busy", 128'(busy64), 128'(0));
      chk("idle_out_valid", 128'(ov64), 128'(0));
    end
    set_ops(x64, z64, x16, z16, x8, z8);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      k++;
      if (timing) begin
        chk($sformatf("busy_c%0d", k), 128'(busy64), 128'(1));
        chk($sformatf("in_ready_c%0d", k), 128'(ir64), 128'(0));
        chk($sformatf("out_valid_c%0d", k), 128'(ov64), 128'(k == LAT));
      end
    end while (ov64 !== 1'b1 && k < LAT + 8);
    if (timing) chk("latency", 128'(k), 128'(LAT));
    else chk("done_valid", 128'(ov64), 128'(1));
    chk("y64", 128'(y64), exp64);
    chk("y16", 128'(y16), exp16);
    chk("y8", 128'(y8), exp8);
    chk("lockstep_valid", 128'({ov16, ov8}), 128'(2'b11));
`ifdef OKA_MOD_REDUCE_EN
    chk("yr64", 128'(yr64), 128'(expr64));
    chk("yr16", 128'(yr16), 128'(expr16));
    chk("yr8", 128'(yr8), 128'(expr8));
`endif
  endtask

  initial begin
    logic [127:0] bp_exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_ops('0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(ir64), 128'(1));
    chk("rst_out_valid", 128'(ov64), 128'(0));
    chk("rst_busy", 128'(busy64), 128'(0));
    chk("rst_y64", 128'(y64), 128'(0));
    chk("rst_y8", 128'(y8), 128'(0));
    rst_n = 1'b1;

    // Directed corner cases.
    do_op(64'd1, 64'd1, 16'd1, 16'd1, 8'd1, 8'd1, 1'b1);
    chk("y64_1x1", 128'(y64), 128'(1));
    do_op(64'd3, 64'd3, 16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 1'b1);
    chk("y64_3x3", 128'(y64), 128'(5));
    chk("y8_ffxff", 128'(y8), 128'(15'h5555));
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 16'h8000, 16'h8000, 8'h57, 8'h83, 1'b1);
    chk("y64_top", 128'(y64), 128'(1) << 126);
`ifdef OKA_MOD_REDUCE_EN
    chk("yr8_aes", 128'(yr8), 128'(8'hC1));
`endif
    do_op(64'h8000_0000_0000_0000, 64'd2, 16'h0, 16'h1234, 8'hA5, 8'h0, 1'b1);
    chk("y16_zero", 128'(y16), 128'(0));
    chk("y8_zero", 128'(y8), 128'(0));
`ifdef OKA_MOD_REDUCE_EN
    chk("yr64_fold", 128'(yr64), 128'(64'h1B));
`endif

    // Backpressure: result held, in_valid pulses ignored.
    @(negedge clk);
    set_ops({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom),
            8'($urandom), 8'($urandom));
    bp_exp = exp64;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("bp_valid", 128'(ov64), 128'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a64 = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_y_stable", 128'(y64), bp_exp);
      chk("bp_in_ready", 128'(ir64), 128'(0));
      chk("bp_out_valid", 128'(ov64), 128'(1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(ov64), 128'(0));
    chk("bp_release_ready", 128'(ir64), 128'(1));

    // Reset while in S_MID aborts the operation.
    @(negedge clk);
    set_ops(64'hDEAD_BEEF_0123_4567, 64'h0F0F_F0F0_1357_9BDF, 16'h1357, 16'h9BDF, 8'h3C, 8'hC3);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 128'(ov64), 128'(0));
    chk("abort_y", 128'(y64), 128'(0));
    chk("abort_in_ready", 128'(ir64), 128'(1));
    chk("abort_busy", 128'(busy64), 128'(0));
    rst_n = 1'b1;
    do_op({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom),
          8'($urandom), 8'($urandom), 1'b1);

    // Random pairs at all three widths.
    for (int n = 0; n < 10000; n++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom), 16'($urandom),
            8'($urandom), 8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
